// File: rtl/count_pulse_gen.sv
// count_pulse_gen: drives the Slt/En pulse stream for the dual-channel event counter.
// A load of (Count0, Count1) produces Count0 pulses on channel 0, then Count1*DIV
// pulses on channel 1. Optional GAP idle cycles separate pulses; Hold freezes progress.
module count_pulse_gen #(
  parameter int DIV = 4,  // channel-1 pulses per channel-1 count, 1..8
  parameter int GAP = 0   // idle cycles between consecutive pulses, 0..255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [63:0] Count0,
  input  logic [63:0] Count1,
  input  logic        Hold,
  output logic        En,
  output logic        Slt,
  output logic        Busy,
  output logic        Done
);

  localparam int              SW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0]   SUB_MAX = SW'(DIV - 1);
  localparam logic [7:0]      GAP_LD  = 8'(GAP);

  typedef enum logic [1:0] {IDLE, SEND0, SEND1, DONE} state_t;

  // Bookkeeping after issuing one pulse from a given starting point.
  typedef struct packed {
    logic          ch1;
    logic [63:0]   rem0;
    logic [63:0]   rem1;
    logic [SW-1:0] sub;
  } pulse_t;

  state_t        state;
  logic [63:0]   rem0;
  logic [63:0]   rem1;
  logic [SW-1:0] sub;
  logic [7:0]    gap_cnt;

  logic [63:0]   src_rem0;
  logic [63:0]   src_rem1;
  logic [SW-1:0] src_sub;
  pulse_t        nxt;
  logic          more;
  logic          sending;
  logic          issue;
  logic          load_empty;

  // Next-pulse computation. In IDLE the counts come straight off the ports so the
  // first pulse can leave on the accepting edge; rem1 counts whole channel-1 counts
  // and only drops when the sub-count wraps, so no Count1*DIV product is needed.
  always_comb begin
    src_rem0   = (state == IDLE) ? Count0 : rem0;
    src_rem1   = (state == IDLE) ? Count1 : rem1;
    src_sub    = (state == IDLE) ? '0     : sub;
    nxt.ch1    = (src_rem0 == 64'd0);
    nxt.rem0   = src_rem0;
    nxt.rem1   = src_rem1;
    nxt.sub    = src_sub;
    if (!nxt.ch1) begin
      nxt.rem0 = src_rem0 - 64'd1;
    end else if (src_sub == SUB_MAX) begin
      nxt.sub  = '0;
      nxt.rem1 = src_rem1 - 64'd1;
    end else begin
      nxt.sub  = src_sub + SW'(1);
    end
    more       = (rem0 != 64'd0) || (rem1 != 64'd0);
    sending    = (state == SEND0) || (state == SEND1);
    load_empty = (Count0 == 64'd0) && (Count1 == 64'd0);
    issue      = ((state == IDLE) && Start && !load_empty) ||
                 (sending && !Hold && more && (gap_cnt == 8'd0));
  end

  // Sequencer: all outputs registered; Reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      rem0    <= '0;
      rem1    <= '0;
      sub     <= '0;
      gap_cnt <= '0;
      En      <= 1'b0;
      Slt     <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else if (issue) begin
      state   <= nxt.ch1 ? SEND1 : SEND0;
      rem0    <= nxt.rem0;
      rem1    <= nxt.rem1;
      sub     <= nxt.sub;
      gap_cnt <= GAP_LD;
      En      <= 1'b1;
      Slt     <= nxt.ch1;
      Busy    <= 1'b1;
      Done    <= 1'b0;
    end else begin
      En <= 1'b0;
      case (state)
        IDLE: begin
          Slt  <= 1'b0;
          Done <= 1'b0;
          if (Start && load_empty) begin
            state <= DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end
        end
        SEND0, SEND1: begin
          // Hold freezes counters and the gap timer; Slt keeps its value.
          if (!Hold) begin
            if (!more) begin
              state   <= DONE;
              gap_cnt <= '0;
              Slt     <= 1'b0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end else if (gap_cnt != 8'd0) begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_pulse_gen.sv
// Bench for count_pulse_gen: three instances with different DIV/GAP share one
// stimulus stream; each is compared every cycle against an expected-output queue
// built from the pulse-list description of a sequence.
module tb_count_pulse_gen;

  localparam int ND = 3;
  localparam int DIVS [ND] = '{4, 4, 1};
  localparam int GAPS [ND] = '{0, 2, 1};
  localparam int CAP = 1200;
  localparam int QD  = 4096;
  localparam int BUDGET = 2000;

  typedef struct packed {logic en; logic slt; logic busy; logic done;} out_t;

  logic        Clk = 1'b0;
  logic        Reset, Start, Hold;
  logic [63:0] Count0, Count1;
  logic [ND-1:0] en, slt, busy, done;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q [ND][QD];
  int   head [ND];
  int   tail [ND];
  out_t cur [ND];

  always #5 Clk = ~Clk;

  count_pulse_gen #(.DIV(4), .GAP(0)) u_d0 (.Clk(Clk), .Reset(Reset), .Start(Start),
    .Count0(Count0), .Count1(Count1), .Hold(Hold), .En(en[0]), .Slt(slt[0]),
    .Busy(busy[0]), .Done(done[0]));
  count_pulse_gen #(.DIV(4), .GAP(2)) u_d1 (.Clk(Clk), .Reset(Reset), .Start(Start),
    .Count0(Count0), .Count1(Count1), .Hold(Hold), .En(en[1]), .Slt(slt[1]),
    .Busy(busy[1]), .Done(done[1]));
  count_pulse_gen #(.DIV(1), .GAP(1)) u_d2 (.Clk(Clk), .Reset(Reset), .Start(Start),
    .Count0(Count0), .Count1(Count1), .Hold(Hold), .En(en[2]), .Slt(slt[2]),
    .Busy(busy[2]), .Done(done[2]));

  function automatic out_t obs(int d);
    return out_t'({en[d], slt[d], busy[d], done[d]});
  endfunction

  task automatic push(int d, out_t o);
    if (tail[d] < QD) begin
      exp_q[d][tail[d]] = o;
      tail[d]++;
    end
  endtask

  // Expected trace: Count0 channel-0 pulses then Count1*DIV channel-1 pulses,
  // GAP idle cycles after every pulse but the last, then one Done cycle.
  task automatic build(int d);
    logic [71:0] n0, n1, tot;
    int nn;
    logic s;
    n0 = {8'd0, Count0};
    n1 = {8'd0, Count1} * 72'(DIVS[d]);
    tot = n0 + n1;
    head[d] = 0;
    tail[d] = 0;
    nn = (tot > 72'(CAP)) ? CAP : int'(tot);
    for (int i = 0; i < nn; i++) begin
      s = (72'(i) >= n0);
      push(d, '{1'b1, s, 1'b1, 1'b0});
      if (72'(i) != tot - 72'd1)
        for (int g = 0; g < GAPS[d]; g++) push(d, '{1'b0, s, 1'b1, 1'b0});
    end
    if (tot <= 72'(CAP)) push(d, '{1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic model_step(int d);
    if (Reset) begin
      cur[d] = '0; head[d] = 0; tail[d] = 0;
    end else if (cur[d].done) begin
      cur[d] = '0;
    end else if (head[d] == tail[d]) begin
      if (Start) begin
        build(d);
        cur[d] = exp_q[d][head[d]];
        head[d]++;
      end else cur[d] = '0;
    end else if (Hold) begin
      cur[d] = '{1'b0, cur[d].slt, 1'b1, 1'b0};
    end else begin
      cur[d] = exp_q[d][head[d]];
      head[d]++;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    for (int d = 0; d < ND; d++) model_step(d);
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      assert (obs(d) === cur[d]) else begin
        errors++;
        $error("FAIL outputs dut%0d t=%0t en/slt/busy/done got=%b exp=%b", d, $time, obs(d), cur[d]);
      end
    end
  endtask

  task automatic run(input logic [63:0] c0, input logic [63:0] c1, input int hold_at,
                     input int hold_len, input int rst_at, input bit chk_lat);
    longint n0 [ND];
    longint n1 [ND];
    int     dcyc [ND];
    bit     all_done;
    longint p, lat;
    for (int d = 0; d < ND; d++) begin n0[d] = 0; n1[d] = 0; dcyc[d] = 0; end
    Start = 1'b1; Count0 = c0; Count1 = c1; Reset = 1'b0;
    Hold = 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (cyc > 1) begin
        Start  = (cyc == 2);
        Count0 = {$urandom, $urandom};
        Count1 = {$urandom, $urandom};
        Hold   = (cyc >= hold_at) && (cyc < hold_at + hold_len);
        Reset  = (cyc == rst_at);
      end
      tick();
      all_done = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (en[d]) begin if (slt[d]) n1[d]++; else n0[d]++; end
        if (done[d] && dcyc[d] == 0) dcyc[d] = cyc;
        if (dcyc[d] == 0) all_done = 1'b0;
      end
      if (cyc == rst_at) begin
        checks++;
        assert ({en, slt, busy, done} === '0) else begin
          errors++;
          $error("FAIL reset_clears got=%b exp=0", {en, slt, busy, done});
        end
        break;
      end
      if (all_done && rst_at == 0) break;
    end
    Start = 1'b0; Hold = 1'b0; Reset = 1'b0; Count0 = '0; Count1 = '0;
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      if (rst_at == 0) begin
        checks++;
        assert (dcyc[d] != 0) else begin
          errors++; $error("FAIL done_timeout dut%0d got=none exp=Done", d);
        end
        checks++;
        assert (n0[d] == longint'(c0)) else begin
          errors++; $error("FAIL ch0_pulses dut%0d got=%0d exp=%0d", d, n0[d], c0);
        end
        checks++;
        assert (n1[d] == longint'(c1) * DIVS[d]) else begin
          errors++; $error("FAIL ch1_pulses dut%0d got=%0d exp=%0d", d, n1[d], longint'(c1) * DIVS[d]);
        end
        if (chk_lat) begin
          p   = longint'(c0) + longint'(c1) * DIVS[d];
          lat = (p == 0) ? 1 : p + (p - 1) * GAPS[d] + 1 + hold_len;
          checks++;
          assert (longint'(dcyc[d]) == lat) else begin
            errors++; $error("FAIL done_cycle dut%0d got=%0d exp=%0d", d, dcyc[d], lat);
          end
        end
      end else if (c0 == '1) begin
        checks++;
        assert (n1[d] == 0 && dcyc[d] == 0) else begin
          errors++; $error("FAIL no_early_end dut%0d got ch1=%0d done_cyc=%0d exp=0/0", d, n1[d], dcyc[d]);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin cur[d] = '0; head[d] = 0; tail[d] = 0; end
    Reset = 1'b1; Start = 1'b0; Hold = 1'b0; Count0 = '0; Count1 = '0;
    tick();
    tick();
    checks++;
    assert ({en, slt, busy, done} === '0) else begin
      errors++; $error("FAIL reset_state got=%b exp=0", {en, slt, busy, done});
    end
    Reset = 1'b0;
    tick();

    run(64'd3, 64'd2, 0, 0, 0, 1'b1);
    run(64'd0, 64'd0, 0, 0, 0, 1'b1);
    run(64'd0, 64'd1, 0, 0, 0, 1'b1);
    run(64'd2, 64'd1, 0, 0, 0, 1'b1);
    run(64'd3, 64'd3, 6, 5, 0, 1'b1);
    run(64'd5, 64'd2, 0, 0, 3, 1'b0);
    run(64'd1, 64'd0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [63:0] a, b;
      int hl, ha;
      a  = 64'($urandom_range(0, 12));
      b  = 64'($urandom_range(0, 4));
      hl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : 0;
      ha = int'($urandom_range(2, 10));
      run(a, b, ha, hl, 0, hl == 0);
    end
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 1001, 1'b0);
    run(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 300, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
